vga_bitmap_display: RTL and testbench

- Parametrised VGA bitmap display engine; successor to the fixed-mode start-screen display path.
- Merges sync generation, ROM address generation and pixel colouring into one pipelined block.
- Places a 1-bit-per-pixel ROM bitmap (one ROM word per bitmap row) at a programmable origin with power-of-two scaling.
- Output is multi-bit RGB with run-time foreground/background colours.
- Feeds board VGA pins directly; an external synchronous ROM instance supplies the bitmap.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing_gen.sv | 50 +++++
 rtl/vga_bitmap_display.sv | 168 ++++++++++++++++
 tb/tb_vga_bitmap_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, colour channel offsets and a width helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_pkg;

    // 800x600 @ 60 Hz timing on a 40 MHz pixel clock
    localparam int VGA_H_VIS  = 800;
    localparam int VGA_H_FP   = 40;
    localparam int VGA_H_SYNC = 128;
    localparam int VGA_H_BP   = 88;
    localparam int VGA_V_VIS  = 600;
    localparam int VGA_V_FP   = 1;
    localparam int VGA_V_SYNC = 4;
    localparam int VGA_V_BP   = 23;

    // Channel index inside a packed {R,G,B} colour word; slice = idx*COLOR_W +: COLOR_W
    localparam int R_IDX = 2;
    localparam int G_IDX = 1;
    localparam int B_IDX = 0;

    // Ceiling log2, never below 1 so it can size a bus directly
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v counters with combinational active/sync decode of the current count.
// Latency: decode is combinational from the counter registers (stage 0).
// Backpressure: none; counts every clock.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP,
    parameter int H_W    = clog2(H_VIS + H_FP + H_SYNC + H_BP),
    parameter int V_W    = clog2(V_VIS + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           active,
    output logic           hs,
    output logic           vs
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Pixel counter wraps each line; line counter steps on the pixel wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_W'(H_TOT - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_W'(V_TOT - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Visible-area and sync-window decode of the current count
    always_comb begin
        active = (32'(h_cnt) < H_VIS) && (32'(v_cnt) < V_VIS);
        hs     = (32'(h_cnt) >= H_VIS + H_FP) && (32'(h_cnt) < H_VIS + H_FP + H_SYNC);
        vs     = (32'(v_cnt) >= V_VIS + V_FP) && (32'(v_cnt) < V_VIS + V_FP + V_SYNC);
    end

endmodule

// File: rtl/vga_bitmap_display.sv
// Places a scaled 1bpp ROM bitmap on a VGA raster with fg/bg colouring; optional blink via VGA_BITMAP_BLINK_EN.
// Latency: ROM_LAT+2 clocks from counter to pins, equal for colour, sync and frame_start.
// Backpressure: none; free-running raster, ROM must answer exactly ROM_LAT clocks after rom_addr.
module vga_bitmap_display
    import vga_pkg::*;
#(
    parameter int H_VIS    = VGA_H_VIS,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_VIS    = VGA_V_VIS,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int SYNC_POL = 1,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int X0       = 272,
    parameter int Y0       = 172,
    parameter int SCALE_SH = 0,
    parameter int ROM_LAT  = 1,
    parameter int COLOR_W  = 1
) (
    input  logic                      CLK_40M,
    input  logic                      RSTn,
    input  logic [3*COLOR_W-1:0]      fg_color,
    input  logic [3*COLOR_W-1:0]      bg_color,
    output logic [clog2(IMG_H)-1:0]   rom_addr,
    input  logic [IMG_W-1:0]          rom_data,
    output logic [COLOR_W-1:0]        vga_red,
    output logic [COLOR_W-1:0]        vga_green,
    output logic [COLOR_W-1:0]        vga_blue,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      frame_start
);

    localparam int   H_W      = clog2(H_VIS + H_FP + H_SYNC + H_BP);
    localparam int   V_W      = clog2(V_VIS + V_FP + V_SYNC + V_BP);
    localparam int   CW       = clog2(IMG_W);
    localparam int   AW       = clog2(IMG_H);
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_rom_lat
        $error("vga_bitmap_display: ROM_LAT must be in 1..4");
    end

    // Per-pixel sideband that travels alongside the ROM access
    typedef struct packed {
        logic          active;
        logic          in_img;
        logic [CW-1:0] col;
        logic          hs;
        logic          vs;
        logic          frm;
    } sb_t;

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           active, hs, vs;
    logic [31:0]    hx, vy;
    logic [AW-1:0]  row;
    sb_t            s0;
    sb_t            pipe [ROM_LAT+1];
    sb_t            sf;

    vga_timing_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_W(H_W), .V_W(V_W)
    ) u_timing (
        .clk    (CLK_40M),
        .rst_n  (RSTn),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs     (hs),
        .vs     (vs)
    );

    // Stage 0: image window test and bitmap coordinates; parts past the visible edge are clipped by active
    always_comb begin
        hx        = 32'(h_cnt);
        vy        = 32'(v_cnt);
        s0.active = active;
        s0.in_img = active
                    && (hx >= X0) && (hx < X0 + (IMG_W << SCALE_SH))
                    && (vy >= Y0) && (vy < Y0 + (IMG_H << SCALE_SH));
        s0.col    = CW'((hx - X0) >> SCALE_SH);
        s0.hs     = hs;
        s0.vs     = vs;
        s0.frm    = (h_cnt == '0) && (v_cnt == '0);
        row       = AW'((vy - Y0) >> SCALE_SH);
    end

    // Stage 1 issues the ROM row; sideband is delayed ROM_LAT+1 deep to meet the returning word
    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            rom_addr <= '0;
            for (int i = 0; i <= ROM_LAT; i++) pipe[i] <= '0;
        end else begin
            rom_addr <= s0.in_img ? row : '0;
            pipe[0]  <= s0;
            for (int i = 1; i <= ROM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign sf = pipe[ROM_LAT];

    logic hide;
`ifdef VGA_BITMAP_BLINK_EN
    // Frame index: the first frame after reset is 0, each later frame start advances it by one
    logic [7:0] blink_cnt, blink_nxt;
    logic       blink_arm;

    // Next frame index, applied already on the pixel that carries the frame flag
    always_comb begin
        blink_nxt = (sf.frm && blink_arm) ? blink_cnt + 8'd1 : blink_cnt;
        hide      = blink_nxt[5];
    end

    // Frame index register; arm skips the very first frame flag so frame 0 counts as 0
    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            blink_cnt <= '0;
            blink_arm <= 1'b0;
        end else begin
            blink_cnt <= blink_nxt;
            if (sf.frm) blink_arm <= 1'b1;
        end
    end
`else
    assign hide = 1'b0;
`endif

    logic [CW-1:0]        bit_idx;
    logic                 pix_bit;
    logic [3*COLOR_W-1:0] rgb;

    // Final-stage colour pick; column 0 is the ROM word MSB
    always_comb begin
        bit_idx = CW'(IMG_W - 1) - sf.col;
        pix_bit = rom_data[bit_idx];
        if (!sf.active)                      rgb = '0;
        else if (sf.in_img && !hide && pix_bit) rgb = fg_color;
        else                                 rgb = bg_color;
    end

    // Output registers drive the pins directly
    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            frame_start <= 1'b0;
        end else begin
            vga_red     <= rgb[R_IDX*COLOR_W +: COLOR_W];
            vga_green   <= rgb[G_IDX*COLOR_W +: COLOR_W];
            vga_blue    <= rgb[B_IDX*COLOR_W +: COLOR_W];
            hsync       <= sf.hs ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= sf.vs ? SYNC_ACT : ~SYNC_ACT;
            frame_start <= sf.frm;
        end
    end

endmodule

// File: tb/tb_vga_bitmap_display.sv
// Scoreboard bench for vga_bitmap_display on a reduced raster with scaling, clipping and active-low sync.
// Latency: expects outputs ROM_LAT+2 clocks after the modelled counter position.
// Backpressure: n/a.
module tb_vga_bitmap_display;
    import vga_pkg::*;

    localparam int H_VIS = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
    localparam int V_VIS = 30, V_FP = 2, V_SYNC = 3, V_BP = 3;
    localparam int SYNC_POL = 0;
    localparam int IMG_W = 16, IMG_H = 8, X0 = 10, Y0 = 6, SCALE_SH = 1;
    localparam int ROM_LAT = 2, COLOR_W = 2;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int SCL = 1 << SCALE_SH;
    localparam int L = ROM_LAT + 2;
    localparam int AW = 3;
    localparam logic [8:0] RESET_VEC = 9'b000000_1_1_0;

    logic                   CLK_40M = 1'b0;
    logic                   RSTn = 1'b0;
    logic [3*COLOR_W-1:0]   fg_color, bg_color;
    logic [AW-1:0]          rom_addr;
    logic [IMG_W-1:0]       rom_data;
    logic [COLOR_W-1:0]     vga_red, vga_green, vga_blue;
    logic                   hsync, vsync, frame_start;

    vga_bitmap_display #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .X0(X0), .Y0(Y0), .SCALE_SH(SCALE_SH), .ROM_LAT(ROM_LAT), .COLOR_W(COLOR_W)
    ) dut (
        .CLK_40M(CLK_40M), .RSTn(RSTn), .fg_color(fg_color), .bg_color(bg_color),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #12 CLK_40M = ~CLK_40M;

    // Synchronous ROM with ROM_LAT register stages
    logic [IMG_W-1:0] img      [IMG_H];
    logic [IMG_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge CLK_40M) begin
        rom_pipe[0] <= img[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    typedef struct packed {
        logic [1:0] cls;   // 0 blank, 1 background, 2 foreground
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int mh, mv, mframe;
    int rel_cyc, last_fs, fs_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h (h=%0d v=%0d)", tag, obs, exp, mh, mv);
        end
    endtask

    function automatic bit in_image(input int h, input int v);
        return (h < H_VIS) && (v < V_VIS) && (h >= X0) && (h < X0 + IMG_W * SCL)
               && (v >= Y0) && (v < Y0 + IMG_H * SCL);
    endfunction

    function automatic int addr_of(input int h, input int v);
        return in_image(h, v) ? (v - Y0) / SCL : 0;
    endfunction

    function automatic exp_t model(input int h, input int v, input int fno);
        exp_t e;
        bit   show;
        logic [IMG_W-1:0] w;
        show = in_image(h, v);
`ifdef VGA_BITMAP_BLINK_EN
        if (((fno >> 5) & 1) != 0) show = 1'b0;
`endif
        if (!((h < H_VIS) && (v < V_VIS))) e.cls = 2'd0;
        else begin
            e.cls = 2'd1;
            if (show) begin
                w = img[(v - Y0) / SCL];
                if (w[IMG_W - 1 - (h - X0) / SCL]) e.cls = 2'd2;
            end
        end
        e.hs = (h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC);
        e.vs = (v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC);
        e.fs = (h == 0) && (v == 0) && (fno >= 0);
        return e;
    endfunction

    function automatic logic [8:0] obs_vec();
        return {vga_red, vga_green, vga_blue, hsync, vsync, frame_start};
    endfunction

    function automatic logic [8:0] exp_vec(input exp_t e);
        logic [5:0] rgb;
        logic       act;
        act = (SYNC_POL != 0);
        rgb = (e.cls == 2'd2) ? fg_color : (e.cls == 2'd1) ? bg_color : 6'd0;
        return {rgb, e.hs ? act : ~act, e.vs ? act : ~act, e.fs};
    endfunction

    task automatic restart_model();
        mh = 0; mv = 0; mframe = 0;
        rel_cyc = 0; last_fs = -1; fs_seen = 0;
        q.delete();
    endtask

    // One negedge per cycle: push expectation for the counter just consumed, pop the one due at the pins
    task automatic run_cycles(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK_40M);
            rel_cyc++;
            q.push_back(model(mh, mv, mframe));
            chk("rom_addr", 32'(rom_addr), 32'(addr_of(mh, mv)));
            if (q.size() == L) begin
                e = q.pop_front();
                chk("pix", 32'(obs_vec()), 32'(exp_vec(e)));
            end else begin
                chk("prefill", 32'(obs_vec()), 32'(RESET_VEC));
            end
            if (frame_start) begin
                if (fs_seen == 0) chk("fs_after_rst", 32'(rel_cyc), 32'(L));
                if (last_fs >= 0) chk("fs_period", 32'(rel_cyc - last_fs), 32'(FRAME));
                last_fs = rel_cyc;
                fs_seen++;
            end
            mh++;
            if (mh == H_TOT) begin
                mh = 0;
                mv++;
                if (mv == V_TOT) begin
                    mv = 0;
                    mframe++;
                end
            end
        end
    endtask

    initial begin
        img[0] = 16'hFFFF; img[1] = 16'h8001; img[2] = 16'hA5A5; img[3] = 16'h0F0F;
        img[4] = 16'h0000; img[5] = 16'h1234; img[6] = 16'hFEDC; img[7] = 16'h8000;
        fg_color = 6'b11_10_01;
        bg_color = 6'b00_01_10;
        restart_model();

        RSTn = 1'b0;
        repeat (3) @(negedge CLK_40M);
        chk("rst_out", 32'(obs_vec()), 32'(RESET_VEC));
        chk("rst_addr", 32'(rom_addr), 32'd0);

        RSTn = 1'b1;
        run_cycles(2 * FRAME + 300);

        // Colour change takes effect on the next output pixel
        fg_color = 6'b01_11_00;
        bg_color = 6'b10_00_11;
        run_cycles(FRAME / 2);

        // Advance to a mid-frame point and reset asynchronously
        for (int k = 0; k < FRAME && !(mh == 25 && mv == 15); k++) run_cycles(1);
        chk("mid_pos", 32'(mh * 1000 + mv), 32'(25 * 1000 + 15));
        RSTn = 1'b0;
        #1;
        chk("mid_rst_out", 32'(obs_vec()), 32'(RESET_VEC));
        chk("mid_rst_addr", 32'(rom_addr), 32'd0);
        repeat (2) @(negedge CLK_40M);
        chk("mid_rst_hold", 32'(obs_vec()), 32'(RESET_VEC));

        restart_model();
        RSTn = 1'b1;
        run_cycles(FRAME + 200);
        chk("fs_count", 32'(fs_seen), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
